// File: rtl/prefetch_stream.sv
// prefetch_stream: next-line instruction prefetcher.
// Streams up to PREF_DEPTH sequential lines after a demand fetch, tracks up to
// NUM_MSHR outstanding memory tags, and writes returning lines into the Icache.
// It yields to demand misses and abandons in-flight data on a branch.
module prefetch_stream #(
  parameter int ADDR_W     = 16,
  parameter int IDX_W      = 5,
  parameter int PREF_DEPTH = 4,
  parameter int NUM_MSHR   = 4,
  parameter int MEM_TAG_W  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 want_to_fetch,
  input  logic [ADDR_W-1:0]    fetch_addr,
  input  logic                 branch,
  input  logic                 give_way,
  output logic [ADDR_W-1:0]    probe_addr,
  input  logic                 probe_hit,
  output logic [1:0]           pref_command,
  output logic [ADDR_W-1:0]    pref_addr,
  input  logic [MEM_TAG_W-1:0] mem_response,
  input  logic [MEM_TAG_W-1:0] mem_tag,
  input  logic [63:0]          mem_data,
  output logic                 pref_wr_en,
  output logic [IDX_W-1:0]     pref_wr_index,
  output logic [ADDR_W-4-IDX_W:0] pref_wr_tag,
  output logic [63:0]          pref_wr_data,
  output logic                 busy,
  output logic                 stream_done
);

  localparam int TAG_W  = ADDR_W - 3 - IDX_W;
  localparam int REM_W  = 4;
  localparam int MIDX_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   cur_addr, cur_addr_next;
  logic [REM_W-1:0]    remaining, remaining_next;

  logic [NUM_MSHR-1:0] mshr_valid;
  logic [NUM_MSHR-1:0] mshr_squashed;
  logic [MEM_TAG_W-1:0] mshr_mtag [NUM_MSHR];
  logic [IDX_W-1:0]    mshr_idx  [NUM_MSHR];
  logic [TAG_W-1:0]    mshr_tag  [NUM_MSHR];

  logic                free_found;
  logic [MIDX_W-1:0]   free_sel;
  logic                hit_found;
  logic [MIDX_W-1:0]   hit_sel;

  logic                active;
  logic                issue;
  logic                skip;
  logic                accepted;
  logic                advance;

  // Find the lowest-numbered free MSHR for the next allocation.
  always_comb begin
    free_found = 1'b0;
    free_sel   = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (!mshr_valid[i]) begin
        free_found = 1'b1;
        free_sel   = MIDX_W'(i);
      end
    end
  end

  // Match the returning memory tag against the outstanding MSHRs.
  always_comb begin
    hit_found = 1'b0;
    hit_sel   = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (mem_tag != '0 && mshr_valid[i] && mshr_mtag[i] == mem_tag) begin
        hit_found = 1'b1;
        hit_sel   = MIDX_W'(i);
      end
    end
  end

  // Stream control: issue/skip decisions, next stream state and bus outputs.
  always_comb begin
    state_next     = state;
    cur_addr_next  = cur_addr;
    remaining_next = remaining;
    stream_done    = 1'b0;

    active   = (state == RUN) && !give_way && !branch;
    issue    = active && free_found && !probe_hit;
    skip     = active && probe_hit;
    accepted = issue && (mem_response != '0);
    advance  = skip || accepted;

    pref_command = issue ? BUS_LOAD : BUS_NONE;
    pref_addr    = issue ? cur_addr : '0;
    probe_addr   = cur_addr;

    if (advance && remaining == REM_W'(1)) begin
      stream_done = 1'b1;
    end

    if (want_to_fetch) begin
      state_next     = RUN;
      cur_addr_next  = {fetch_addr[ADDR_W-1:3] + (ADDR_W-3)'(1), 3'b000};
      remaining_next = REM_W'(PREF_DEPTH);
    end else if (branch) begin
      state_next     = IDLE;
      remaining_next = '0;
    end else if (advance) begin
      cur_addr_next  = cur_addr + ADDR_W'(8);
      remaining_next = remaining - REM_W'(1);
      if (remaining == REM_W'(1)) begin
        state_next = IDLE;
      end
    end

    pref_wr_en    = hit_found && !mshr_squashed[hit_sel];
    pref_wr_index = pref_wr_en ? mshr_idx[hit_sel] : '0;
    pref_wr_tag   = pref_wr_en ? mshr_tag[hit_sel] : '0;
    pref_wr_data  = pref_wr_en ? mem_data : '0;

    busy = (state == RUN) || (|mshr_valid);
  end

  // Stream state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
    end else begin
      state     <= state_next;
      cur_addr  <= cur_addr_next;
      remaining <= remaining_next;
    end
  end

  // MSHR table: squash on branch, free on completion, allocate on acceptance.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mshr_valid    <= '0;
      mshr_squashed <= '0;
      for (int i = 0; i < NUM_MSHR; i++) begin
        mshr_mtag[i] <= '0;
        mshr_idx[i]  <= '0;
        mshr_tag[i]  <= '0;
      end
    end else begin
      if (branch) begin
        mshr_squashed <= mshr_squashed | mshr_valid;
      end
      if (hit_found) begin
        mshr_valid[hit_sel] <= 1'b0;
      end
      if (accepted) begin
        mshr_valid[free_sel]    <= 1'b1;
        mshr_squashed[free_sel] <= 1'b0;
        mshr_mtag[free_sel]     <= mem_response;
        mshr_idx[free_sel]      <= cur_addr[IDX_W+2:3];
        mshr_tag[free_sel]      <= cur_addr[ADDR_W-1:IDX_W+3];
      end
    end
  end

endmodule

// File: tb/tb_prefetch_stream.sv
// tb_prefetch_stream: directed self-checking bench for prefetch_stream.
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_prefetch_stream;

  localparam logic [63:0] D1 = 64'h1111_2222_3333_0001;
  localparam logic [63:0] D2 = 64'h1111_2222_3333_0002;
  localparam logic [63:0] D3 = 64'h1111_2222_3333_0003;
  localparam logic [63:0] D5 = 64'h1111_2222_3333_0005;

  logic        clock;
  logic        reset;
  logic        reset6;
  logic        want_to_fetch;
  logic        want6;
  logic [15:0] fetch_addr;
  logic        branch;
  logic        give_way;
  logic        probe_hit;
  logic [3:0]  mem_response;
  logic [3:0]  mem_tag;
  logic [63:0] mem_data;

  logic [15:0] probe_addr;
  logic [1:0]  pref_command;
  logic [15:0] pref_addr;
  logic        pref_wr_en;
  logic [4:0]  pref_wr_index;
  logic [7:0]  pref_wr_tag;
  logic [63:0] pref_wr_data;
  logic        busy;
  logic        stream_done;

  logic [15:0] probe_addr6;
  logic [1:0]  pref_command6;
  logic [15:0] pref_addr6;
  logic        pref_wr_en6;
  logic [4:0]  pref_wr_index6;
  logic [7:0]  pref_wr_tag6;
  logic [63:0] pref_wr_data6;
  logic        busy6;
  logic        stream_done6;

  int checks = 0;
  int errors = 0;

  prefetch_stream dut (
    .clock(clock), .reset(reset), .want_to_fetch(want_to_fetch), .fetch_addr(fetch_addr),
    .branch(branch), .give_way(give_way), .probe_addr(probe_addr), .probe_hit(probe_hit),
    .pref_command(pref_command), .pref_addr(pref_addr), .mem_response(mem_response),
    .mem_tag(mem_tag), .mem_data(mem_data), .pref_wr_en(pref_wr_en),
    .pref_wr_index(pref_wr_index), .pref_wr_tag(pref_wr_tag), .pref_wr_data(pref_wr_data),
    .busy(busy), .stream_done(stream_done)
  );

  prefetch_stream #(.PREF_DEPTH(6)) dut6 (
    .clock(clock), .reset(reset6), .want_to_fetch(want6), .fetch_addr(fetch_addr),
    .branch(branch), .give_way(give_way), .probe_addr(probe_addr6), .probe_hit(probe_hit),
    .pref_command(pref_command6), .pref_addr(pref_addr6), .mem_response(mem_response),
    .mem_tag(mem_tag), .mem_data(mem_data), .pref_wr_en(pref_wr_en6),
    .pref_wr_index(pref_wr_index6), .pref_wr_tag(pref_wr_tag6), .pref_wr_data(pref_wr_data6),
    .busy(busy6), .stream_done(stream_done6)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to the next falling edge with all pulse-type inputs cleared.
  task automatic next_cycle();
    @(negedge clock);
    want_to_fetch = 1'b0;
    want6         = 1'b0;
    branch        = 1'b0;
    give_way      = 1'b0;
    probe_hit     = 1'b0;
    mem_response  = 4'd0;
    mem_tag       = 4'd0;
    mem_data      = 64'd0;
  endtask

  // Reset low for two edges; every output must be zero.
  task automatic test_reset();
    reset = 1'b0; reset6 = 1'b0;
    want_to_fetch = 1'b0; want6 = 1'b0; fetch_addr = 16'd0; branch = 1'b0;
    give_way = 1'b0; probe_hit = 1'b0; mem_response = 4'd0; mem_tag = 4'd0; mem_data = 64'd0;
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++; if (pref_command !== 2'd0) begin errors++; $display("[TB] FAIL rst_cmd got %0d want 0", pref_command); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got %0b want 0", busy); end
    checks++; if (stream_done !== 1'b0 || pref_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL rst_pulses got done=%0b wr=%0b want 0 0", stream_done, pref_wr_en); end
    checks++; if (probe_addr !== 16'h0000 || pref_addr !== 16'h0000) begin errors++; $display("[TB] FAIL rst_addr got probe=%h pref=%h want 0000 0000", probe_addr, pref_addr); end
  endtask

  // Four consecutive issues after fetch 0x0100, stream_done on the fourth.
  task automatic test_stream();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'h0108; exp_addr[1] = 16'h0110; exp_addr[2] = 16'h0118; exp_addr[3] = 16'h0120;
    next_cycle();
    reset = 1'b1; want_to_fetch = 1'b1; fetch_addr = 16'h0100;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      mem_response = 4'(i + 1);
      #1;
      checks++; if (pref_command !== 2'd1 || pref_addr !== exp_addr[i]) begin errors++; $display("[TB] FAIL stream_issue%0d got cmd=%0d addr=%h want 1 %h", i, pref_command, pref_addr, exp_addr[i]); end
      checks++; if (stream_done !== (i == 3)) begin errors++; $display("[TB] FAIL stream_done%0d got %0b want %0b", i, stream_done, (i == 3)); end
    end
    next_cycle();
    #1;
    checks++; if (pref_command !== 2'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL stream_after got cmd=%0d busy=%0b want 0 1", pref_command, busy); end
  endtask

  // Out-of-order returns write the right lines; busy holds until all tags are back.
  task automatic test_returns();
    next_cycle();
    mem_tag = 4'd3; mem_data = D3;
    #1;
    checks++; if (pref_wr_en !== 1'b1 || pref_wr_index !== 5'd3 || pref_wr_tag !== 8'h01 || pref_wr_data !== D3) begin errors++; $display("[TB] FAIL ret_t3 got en=%0b idx=%0d tag=%h data=%h want 1 3 01 %h", pref_wr_en, pref_wr_index, pref_wr_tag, pref_wr_data, D3); end
    next_cycle();
    mem_tag = 4'd1; mem_data = D1;
    #1;
    checks++; if (pref_wr_en !== 1'b1 || pref_wr_index !== 5'd1 || pref_wr_tag !== 8'h01 || pref_wr_data !== D1) begin errors++; $display("[TB] FAIL ret_t1 got en=%0b idx=%0d tag=%h data=%h want 1 1 01 %h", pref_wr_en, pref_wr_index, pref_wr_tag, pref_wr_data, D1); end
    next_cycle();
    mem_tag = 4'd2; mem_data = D2;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ret_busy_t2 got %0b want 1", busy); end
    next_cycle();
    mem_tag = 4'd4;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ret_busy_t4 got %0b want 1", busy); end
    next_cycle();
    mem_tag = 4'd7; mem_data = D5;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ret_idle got %0b want 0", busy); end
    checks++; if (pref_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL ret_stray_tag got %0b want 0", pref_wr_en); end
  endtask

  // Rejected requests hold the address; only the accepted one allocates.
  // A completion in the branch cycle itself still writes.
  task automatic test_retry();
    next_cycle();
    want_to_fetch = 1'b1; fetch_addr = 16'h0100;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      mem_response = (i == 2) ? 4'd5 : 4'd0;
      #1;
      checks++; if (pref_command !== 2'd1 || pref_addr !== 16'h0108) begin errors++; $display("[TB] FAIL retry_hold%0d got cmd=%0d addr=%h want 1 0108", i, pref_command, pref_addr); end
    end
    next_cycle();
    #1;
    checks++; if (pref_addr !== 16'h0110) begin errors++; $display("[TB] FAIL retry_advance got %h want 0110", pref_addr); end
    next_cycle();
    branch = 1'b1; mem_tag = 4'd5; mem_data = D5;
    #1;
    checks++; if (pref_command !== 2'd0) begin errors++; $display("[TB] FAIL retry_branch_cmd got %0d want 0", pref_command); end
    checks++; if (pref_wr_en !== 1'b1 || pref_wr_index !== 5'd1 || pref_wr_tag !== 8'h01 || pref_wr_data !== D5) begin errors++; $display("[TB] FAIL retry_branch_wr got en=%0b idx=%0d tag=%h data=%h want 1 1 01 %h", pref_wr_en, pref_wr_index, pref_wr_tag, pref_wr_data, D5); end
    next_cycle();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL retry_idle got %0b want 0", busy); end
  endtask

  // A probe hit skips a line without a request; four lines are still covered.
  task automatic test_skip();
    next_cycle();
    want_to_fetch = 1'b1; fetch_addr = 16'h0100;
    next_cycle();
    mem_response = 4'd1;
    #1;
    checks++; if (pref_command !== 2'd1 || pref_addr !== 16'h0108) begin errors++; $display("[TB] FAIL skip_first got cmd=%0d addr=%h want 1 0108", pref_command, pref_addr); end
    next_cycle();
    probe_hit = 1'b1;
    #1;
    checks++; if (pref_command !== 2'd0 || probe_addr !== 16'h0110) begin errors++; $display("[TB] FAIL skip_hit got cmd=%0d probe=%h want 0 0110", pref_command, probe_addr); end
    next_cycle();
    mem_response = 4'd2;
    #1;
    checks++; if (pref_command !== 2'd1 || pref_addr !== 16'h0118) begin errors++; $display("[TB] FAIL skip_next got cmd=%0d addr=%h want 1 0118", pref_command, pref_addr); end
    next_cycle();
    mem_response = 4'd3;
    #1;
    checks++; if (pref_addr !== 16'h0120 || stream_done !== 1'b1) begin errors++; $display("[TB] FAIL skip_last got addr=%h done=%0b want 0120 1", pref_addr, stream_done); end
    next_cycle();
    #1;
    checks++; if (pref_command !== 2'd0) begin errors++; $display("[TB] FAIL skip_end got %0d want 0", pref_command); end
    for (int t = 1; t <= 3; t++) begin
      next_cycle();
      mem_tag = 4'(t);
    end
    next_cycle();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL skip_idle got %0b want 0", busy); end
  endtask

  // Branch squashes in-flight data: returns produce no writes.
  task automatic test_branch();
    next_cycle();
    want_to_fetch = 1'b1; fetch_addr = 16'h0100;
    next_cycle(); mem_response = 4'd1;
    next_cycle(); mem_response = 4'd2;
    next_cycle();
    branch = 1'b1;
    #1;
    checks++; if (pref_command !== 2'd0) begin errors++; $display("[TB] FAIL br_cmd got %0d want 0", pref_command); end
    next_cycle();
    mem_tag = 4'd1; mem_data = D1;
    #1;
    checks++; if (pref_wr_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL br_t1 got wr=%0b busy=%0b want 0 1", pref_wr_en, busy); end
    next_cycle();
    mem_tag = 4'd2; mem_data = D2;
    #1;
    checks++; if (pref_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL br_t2 got wr=%0b want 0", pref_wr_en); end
    next_cycle();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL br_idle got %0b want 0", busy); end
  endtask

  // give_way blocks requests; the stream resumes at the same address.
  task automatic test_give_way();
    next_cycle();
    want_to_fetch = 1'b1; fetch_addr = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      give_way = 1'b1; mem_response = 4'd1;
      #1;
      checks++; if (pref_command !== 2'd0 || probe_addr !== 16'h0308) begin errors++; $display("[TB] FAIL gw_hold%0d got cmd=%0d probe=%h want 0 0308", i, pref_command, probe_addr); end
    end
    next_cycle();
    mem_response = 4'd1;
    #1;
    checks++; if (pref_command !== 2'd1 || pref_addr !== 16'h0308) begin errors++; $display("[TB] FAIL gw_resume got cmd=%0d addr=%h want 1 0308", pref_command, pref_addr); end
    next_cycle(); branch = 1'b1;
    next_cycle(); mem_tag = 4'd1;
    next_cycle();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL gw_idle got %0b want 0", busy); end
  endtask

  // Stream address wraps from 0xFFF8 to 0x0000.
  task automatic test_wrap();
    next_cycle();
    want_to_fetch = 1'b1; fetch_addr = 16'hFFF0;
    next_cycle();
    mem_response = 4'd1;
    #1;
    checks++; if (pref_addr !== 16'hFFF8) begin errors++; $display("[TB] FAIL wrap_top got %h want fff8", pref_addr); end
    next_cycle();
    #1;
    checks++; if (pref_command !== 2'd1 || pref_addr !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_zero got cmd=%0d addr=%h want 1 0000", pref_command, pref_addr); end
    next_cycle(); branch = 1'b1;
    next_cycle();
    mem_tag = 4'd1;
    #1;
    checks++; if (pref_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL wrap_squash got %0b want 0", pref_wr_en); end
    next_cycle();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL wrap_idle got %0b want 0", busy); end
  endtask

  // Depth-6 stream with four MSHRs stalls after four issues; a freed slot
  // is reusable only on the cycle after the return.
  task automatic test_mshr_full();
    logic [15:0] exp_addr [4];
    exp_addr[0] = 16'h0208; exp_addr[1] = 16'h0210; exp_addr[2] = 16'h0218; exp_addr[3] = 16'h0220;
    next_cycle(); reset6 = 1'b1;
    next_cycle(); want6 = 1'b1; fetch_addr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      mem_response = 4'(i + 1);
      #1;
      checks++; if (pref_command6 !== 2'd1 || pref_addr6 !== exp_addr[i]) begin errors++; $display("[TB] FAIL full_issue%0d got cmd=%0d addr=%h want 1 %h", i, pref_command6, pref_addr6, exp_addr[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      mem_response = 4'd5;
      #1;
      checks++; if (pref_command6 !== 2'd0 || busy6 !== 1'b1) begin errors++; $display("[TB] FAIL full_stall%0d got cmd=%0d busy=%0b want 0 1", i, pref_command6, busy6); end
    end
    next_cycle();
    mem_tag = 4'd2; mem_response = 4'd5;
    #1;
    checks++; if (pref_command6 !== 2'd0) begin errors++; $display("[TB] FAIL full_same_cycle got %0d want 0", pref_command6); end
    next_cycle();
    mem_response = 4'd5;
    #1;
    checks++; if (pref_command6 !== 2'd1 || pref_addr6 !== 16'h0228) begin errors++; $display("[TB] FAIL full_fifth got cmd=%0d addr=%h want 1 0228", pref_command6, pref_addr6); end
    next_cycle();
    mem_response = 4'd6;
    #1;
    checks++; if (pref_command6 !== 2'd0) begin errors++; $display("[TB] FAIL full_again got %0d want 0", pref_command6); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_stream();
    test_returns();
    test_retry();
    test_skip();
    test_branch();
    test_give_way();
    test_wrap();
    test_mshr_full();
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_stream.md
Name: prefetch_stream

Overview:
- Parametrised next-line instruction prefetcher; successor to the single-request prefetcher.
- Sits between the fetch stage / Icache and the memory bus arbiter.
- On a fetch trigger it streams up to PREF_DEPTH sequential lines past the demand line. It tracks up to NUM_MSHR outstanding memory tags and writes returning lines into Icache memory.
- It yields the bus to demand misses, and on a branch it abandons the stream and drops the data of requests still in flight.

Parameters:
- ADDR_W, 16, byte-address width; line = 8 bytes.
- IDX_W, 5, Icache index bits; tag width TAG_W = ADDR_W-3-IDX_W (8 by default).
- PREF_DEPTH, 4, lines prefetched per trigger (1..15).
- NUM_MSHR, 4, outstanding request slots (1..15).
- MEM_TAG_W, 4, memory tag width; tag 0 means "none".

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- want_to_fetch  in  1  one-cycle trigger; start a stream after fetch_addr
- fetch_addr  in  ADDR_W  demand address accompanying want_to_fetch
- branch  in  1  redirect; abandon stream, squash in-flight requests
- give_way  in  1  demand miss owns the bus this cycle
- probe_addr  out  ADDR_W  line address being probed (= cur_addr)
- probe_hit  in  1  combinational: probe_addr line valid in Icache
- pref_command  out  2  BUS_NONE=0 / BUS_LOAD=1
- pref_addr  out  ADDR_W  request address, 8-byte aligned
- mem_response  in  MEM_TAG_W  tag accepted this cycle; 0 = rejected
- mem_tag  in  MEM_TAG_W  tag of data returning this cycle; 0 = none
- mem_data  in  64  returning line data
- pref_wr_en  out  1  write returning line into Icache
- pref_wr_index  out  IDX_W  write index
- pref_wr_tag  out  TAG_W  write tag
- pref_wr_data  out  64  write data (= mem_data)
- busy  out  1  stream active or any MSHR valid
- stream_done  out  1  one-cycle pulse when the stream finishes issuing

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, all MSHRs invalid, remaining=0. All outputs 0 in the following cycle.
- FSM states IDLE, RUN.
  - IDLE→RUN on want_to_fetch: cur_addr = {fetch_addr[ADDR_W-1:3]+1, 3'b0}, remaining = PREF_DEPTH.
  - RUN→IDLE when remaining reaches 0; stream_done pulses that cycle.
  - Any state→IDLE on branch with no want_to_fetch.
- Issue condition (combinational): RUN && !give_way && !branch && a free MSHR exists && !probe_hit.
  - Under issue: pref_command=BUS_LOAD, pref_addr=cur_addr. Otherwise pref_command=BUS_NONE.
- RUN && !give_way && !branch && probe_hit: skip. Advance cur_addr by 8, remaining-1, no request issued. A skip does not require a free MSHR.
- Issued and mem_response!=0: allocate the lowest free MSHR {valid, squashed=0, mem tag, index, tag from cur_addr}, then advance cur_addr and decrement remaining.
- Issued and mem_response==0: hold cur_addr and retry next cycle.
- No free MSHR: hold, no request.
- give_way: no request and no advance; the stream resumes when give_way drops.
- cur_addr wraps modulo 2^ADDR_W.
- Completion: mem_tag!=0 matching a valid MSHR.
  - If not squashed: pref_wr_en=1 in the same cycle (combinational), with that entry's index/tag and mem_data.
  - The entry is freed at the next edge and is usable for allocation that next cycle, not the same cycle.
  - A squashed entry is freed with no write.
  - mem_tag matching no entry, or mem_tag==0: ignored.
- branch: every valid MSHR is marked squashed; the stream is cleared.
  - A completion arriving in the branch cycle itself still writes: the line is correct, only future data is abandoned.
- branch && want_to_fetch in the same cycle: old MSHRs are squashed and the new stream starts from fetch_addr.
- want_to_fetch while in RUN: restart the stream from the new fetch_addr. Existing MSHRs are kept unsquashed.
- Allocation and completion in the same cycle are both honoured.
- busy = (state==RUN) || any MSHR valid.

Test Plan:
- Reset low 2 cycles, then high; pulse want_to_fetch with fetch_addr=0x0100, probe_hit=0, mem_response=1,2,3,4 → BUS_LOAD at 0x0108, 0x0110, 0x0118, 0x0120 on consecutive cycles; stream_done pulses at the 4th issue; busy stays 1 until all four tags return.
- Return tags 3,1 with data D3,D1 → pref_wr_en on each; index/tag decode 0x0118 then 0x0108; busy drops after tags 2,4 return.
- mem_response=0 for 2 cycles, then 5 → pref_addr held at 0x0108 for 3 cycles, MSHR allocated only on the 3rd.
- probe_hit=1 for 0x0110 → no request for 0x0110; the next request is 0x0118, still 4 lines covered.
- NUM_MSHR=4, no returns, PREF_DEPTH=6 → 4 issues, then BUS_NONE; a tag return frees a slot and the 5th issue occurs the following cycle.
- Issue tags 1,2; assert branch; return tags 1,2 → pref_wr_en stays 0, busy drops; give_way held high during a new stream → pref_command=BUS_NONE throughout, resumes at the same address.
